// File: rtl/trap_array_sequencer_if.sv
// Host / valve-driver bundle for trap_array_sequencer.
// Optional feature macro: ABORT_EN adds the 'abort' request line.
// Handshake: start is a level sampled only while the sequencer is idle, and
// ch_mask/incub_cyc are captured on that same edge. busy tells the host that
// further start pulses are ignored. done and err are single-cycle pulses.
interface trap_array_sequencer_if #(
    parameter int N_CH  = 8,
    parameter int CNT_W = 16
);
    localparam int CH_W = $clog2(N_CH);

    logic              start;
    logic [N_CH-1:0]   ch_mask;
    logic [CNT_W-1:0]  incub_cyc;
`ifdef ABORT_EN
    logic              abort;
`endif
    logic              busy;
    logic              done;
    logic              err;
    logic [N_CH-1:0]   v_in;
    logic              v_chain;
    logic              v_wash;
    logic              v_waste;
    logic              v_iso;
    logic [N_CH-1:0]   v_rel;
    logic [CH_W-1:0]   cur_ch;
    logic [2:0]        state_dbg;

    modport master (
        output start, ch_mask, incub_cyc,
`ifdef ABORT_EN
        output abort,
`endif
        input  busy, done, err, v_in, v_chain, v_wash, v_waste, v_iso,
        input  v_rel, cur_ch, state_dbg
    );

    modport slave (
        input  start, ch_mask, incub_cyc,
`ifdef ABORT_EN
        input  abort,
`endif
        output busy, done, err, v_in, v_chain, v_wash, v_waste, v_iso,
        output v_rel, cur_ch, state_dbg
    );
endinterface

// File: rtl/trap_array_sequencer.sv
// Load / flush / incubate / release sequencer for an N-channel cell-trap mux.
// Optional feature macro: ABORT_EN (abort request skips to flush + done).
// Every valve pattern is separated from the next by GAP_CYC all-closed cycles.
// All outputs are registered: they are decoded from the next state and
// captured on the same edge as the state itself.
module trap_array_sequencer #(
    parameter int N_CH      = 8,
    parameter int CNT_W     = 16,
    parameter int LOAD_CYC  = 4,
    parameter int FLUSH_CYC = 6,
    parameter int REL_CYC   = 3,
    parameter int GAP_CYC   = 2
) (
    input logic clk,
    input logic rst,
    trap_array_sequencer_if.slave bus
);
    localparam int CH_W = $clog2(N_CH);

    // Counters hold "cycles remaining minus one" so the exit test is == 0.
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_CYC - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] REL_LAST   = CNT_W'(REL_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GAP     = 3'd1,
        S_LOAD    = 3'd2,
        S_FLUSH   = 3'd3,
        S_INCUB   = 3'd4,
        S_RELEASE = 3'd5,
        S_DONE    = 3'd6
    } state_e;

    state_e            state_q, state_d;
    state_e            pend_q, pend_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0]  incub_q, incub_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              aborted_q, aborted_d;
    logic              reject;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [N_CH-1:0]   v_in_q, v_in_d;
    logic              v_chain_q, v_chain_d;
    logic              v_wash_q, v_wash_d;
    logic              v_waste_q, v_waste_d;
    logic              v_iso_q, v_iso_d;
    logic [N_CH-1:0]   v_rel_q, v_rel_d;
    logic [CH_W-1:0]   cur_ch_q, cur_ch_d;

    logic [CH_W-1:0]   in_low_ch;
    logic [CH_W-1:0]   low_ch;
    logic [CH_W-1:0]   nxt_ch;
    logic              nxt_found;

    // Channel pickers: lowest bit of the incoming mask, lowest bit of the
    // latched mask, and next latched bit strictly above the current channel.
    always_comb begin
        in_low_ch = '0;
        low_ch    = '0;
        nxt_ch    = '0;
        nxt_found = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (bus.ch_mask[i]) in_low_ch = CH_W'(i);
            if (mask_q[i]) low_ch = CH_W'(i);
            if (mask_q[i] && (i > int'(ch_q))) begin
                nxt_ch    = CH_W'(i);
                nxt_found = 1'b1;
            end
        end
    end

    // State and sequencing registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pend_q    <= S_IDLE;
            ch_q      <= '0;
            mask_q    <= '0;
            incub_q   <= '0;
            cnt_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            ch_q      <= ch_d;
            mask_q    <= mask_d;
            incub_q   <= incub_d;
            cnt_q     <= cnt_d;
            aborted_q <= aborted_d;
        end
    end

    // Next-state logic: every valve state exits through GAP with the
    // following state parked in pend_q.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        ch_d      = ch_q;
        mask_d    = mask_q;
        incub_d   = incub_q;
        cnt_d     = cnt_q;
        aborted_d = aborted_q;
        reject    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.ch_mask != '0) begin
                        state_d   = S_GAP;
                        pend_d    = S_LOAD;
                        ch_d      = in_low_ch;
                        mask_d    = bus.ch_mask;
                        incub_d   = bus.incub_cyc;
                        cnt_d     = GAP_LAST;
                        aborted_d = 1'b0;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    case (pend_q)
                        S_LOAD: begin
                            state_d = S_LOAD;
                            cnt_d   = LOAD_LAST;
                        end
                        S_FLUSH: begin
                            state_d = S_FLUSH;
                            cnt_d   = FLUSH_LAST;
                        end
                        S_INCUB: begin
                            // Zero incubation goes straight to the first release.
                            if (incub_q == '0) begin
                                state_d = S_RELEASE;
                                ch_d    = low_ch;
                                cnt_d   = REL_LAST;
                            end else begin
                                state_d = S_INCUB;
                                cnt_d   = incub_q - 1'b1;
                            end
                        end
                        S_RELEASE: begin
                            state_d = S_RELEASE;
                            cnt_d   = REL_LAST;
                        end
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_LOAD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LAST;
                    if (nxt_found) begin
                        pend_d = S_LOAD;
                        ch_d   = nxt_ch;
                    end else begin
                        pend_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LAST;
                    pend_d  = aborted_q ? S_DONE : S_INCUB;
                end
            end
            S_INCUB: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = S_RELEASE;
                    ch_d    = low_ch;
                    cnt_d   = REL_LAST;
                end
            end
            S_RELEASE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LAST;
                    if (nxt_found) begin
                        pend_d = S_RELEASE;
                        ch_d   = nxt_ch;
                    end else begin
                        pend_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef ABORT_EN
        // A second abort after the first is accepted would only repeat the flush.
        if (bus.abort && !aborted_q &&
            (state_q inside {S_GAP, S_LOAD, S_INCUB, S_RELEASE})) begin
            state_d   = S_GAP;
            pend_d    = S_FLUSH;
            cnt_d     = GAP_LAST;
            aborted_d = 1'b1;
        end
`endif
    end

    // Output decode from the upcoming state so the registered outputs line up
    // with the state register.
    always_comb begin
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        err_d     = reject | (done_d & aborted_d);
        v_in_d    = '0;
        v_chain_d = 1'b0;
        v_wash_d  = 1'b0;
        v_waste_d = 1'b0;
        v_iso_d   = 1'b0;
        v_rel_d   = '0;
        cur_ch_d  = '0;
        case (state_d)
            S_LOAD: begin
                v_in_d    = N_CH'(1) << ch_d;
                v_chain_d = 1'b1;
                v_waste_d = 1'b1;
                cur_ch_d  = ch_d;
            end
            S_FLUSH: begin
                v_wash_d  = 1'b1;
                v_chain_d = 1'b1;
                v_waste_d = 1'b1;
            end
            S_RELEASE: begin
                v_iso_d  = 1'b1;
                v_rel_d  = N_CH'(1) << ch_d;
                cur_ch_d = ch_d;
            end
            default: ;
        endcase
    end

    // Output registers; reset closes every valve on the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            v_in_q    <= '0;
            v_chain_q <= 1'b0;
            v_wash_q  <= 1'b0;
            v_waste_q <= 1'b0;
            v_iso_q   <= 1'b0;
            v_rel_q   <= '0;
            cur_ch_q  <= '0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            v_in_q    <= v_in_d;
            v_chain_q <= v_chain_d;
            v_wash_q  <= v_wash_d;
            v_waste_q <= v_waste_d;
            v_iso_q   <= v_iso_d;
            v_rel_q   <= v_rel_d;
            cur_ch_q  <= cur_ch_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.v_in      = v_in_q;
    assign bus.v_chain   = v_chain_q;
    assign bus.v_wash    = v_wash_q;
    assign bus.v_waste   = v_waste_q;
    assign bus.v_iso     = v_iso_q;
    assign bus.v_rel     = v_rel_q;
    assign bus.cur_ch    = cur_ch_q;
    assign bus.state_dbg = state_q;
endmodule
